ca_frame_receiver: RTL

Receive end of the cellular-automaton generation stream. The CA core emits each 256-bit generation as 16 consecutive 16-bit words, most-significant word first. This block reassembles those words into a full row and presents it with a valid strobe. It also checks that each new row equals the Rule 110 successor of the previous row, and keeps frame, generation and mismatch counters. It sits on the host/bench side of the 16-bit output bus, or in a loopback self-check build.

---
 rtl/ca_frame_receiver.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ca_frame_receiver.sv
// rtl/ca_frame_receiver.sv - reassembles 16-bit CA words into 256-bit rows and checks the Rule 110 succession
module ca_frame_receiver #(
  parameter int WORDS  = 16,
  parameter int WORD_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WORD_W-1:0]       word_in,
  input  logic                    word_valid,
  input  logic                    sof,
  output logic [WORDS*WORD_W-1:0] row_out,
  output logic                    row_valid,
  output logic                    check_valid,
  output logic                    check_ok,
  output logic                    frame_err,
  output logic [CNT_W-1:0]        gen_count,
  output logic [CNT_W-1:0]        err_count
);

  localparam int ROW_W = WORDS * WORD_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [0:0] {S_IDLE, S_COLLECT} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [ROW_W-1:0]   buf_q;
  logic [ROW_W-1:0]   prev_q;
  logic               have_prev_q;
  logic [ROW_W-1:0]   row_q;
  logic               row_valid_q;
  logic               check_valid_q;
  logic               check_ok_q;
  logic               frame_err_q;
  logic [CNT_W-1:0]   gen_q;
  logic [CNT_W-1:0]   err_q;

  logic [IDX_W-1:0]   wr_idx;
  logic [ROW_W-1:0]   row_d;
  logic [ROW_W-1:0]   expected;
  logic [ROW_W-1:0]   left_n;
  logic [ROW_W-1:0]   right_n;

  // Collect buffer with the incoming word merged in; a sof always lands at word 0
  always_comb begin
    wr_idx = sof ? '0 : idx_q;
    row_d  = buf_q;
    for (int k = 0; k < WORDS; k++) begin
      if (wr_idx == IDX_W'(k)) begin
        row_d[ROW_W-1-WORD_W*k -: WORD_W] = word_in;
      end
    end
  end

  // Rule 110 successor of the previous row; cells beyond either edge read as 0
  always_comb begin
    left_n   = prev_q >> 1;
    right_n  = prev_q << 1;
    expected = (left_n & prev_q & ~right_n) | (~left_n & prev_q) | (~prev_q & right_n);
  end

  // Frame FSM, completion bookkeeping and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      buf_q         <= '0;
      prev_q        <= '0;
      have_prev_q   <= 1'b0;
      row_q         <= '0;
      row_valid_q   <= 1'b0;
      check_valid_q <= 1'b0;
      check_ok_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      gen_q         <= '0;
      err_q         <= '0;
    end else begin
      row_valid_q   <= 1'b0;
      check_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (word_valid) begin
            if (sof) begin
              buf_q   <= row_d;
              idx_q   <= IDX_W'(1);
              state_q <= S_COLLECT;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          if (word_valid) begin
            if (sof) begin
              frame_err_q <= 1'b1;
              buf_q       <= row_d;
              idx_q       <= IDX_W'(1);
            end else if (idx_q == IDX_W'(WORDS-1)) begin
              row_q       <= row_d;
              prev_q      <= row_d;
              have_prev_q <= 1'b1;
              row_valid_q <= 1'b1;
              gen_q       <= gen_q + CNT_W'(1);
              idx_q       <= '0;
              state_q     <= S_IDLE;
              if (have_prev_q) begin
                check_valid_q <= 1'b1;
                check_ok_q    <= (row_d == expected);
                if (row_d != expected && err_q != '1) begin
                  err_q <= err_q + CNT_W'(1);
                end
              end
            end else begin
              buf_q <= row_d;
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign row_out     = row_q;
  assign row_valid   = row_valid_q;
  assign check_valid = check_valid_q;
  assign check_ok    = check_ok_q;
  assign frame_err   = frame_err_q;
  assign gen_count   = gen_q;
  assign err_count   = err_q;

endmodule
